// File: rtl/bool_arbiter.sv
// Round-robin front end that shares one per-bit truth-table bool unit among NREQ
// requesters, with a single registered result slot and a fixed 1-cycle latency.

module bool_unit #(
    parameter int DW = 32
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [3:0]    op,
    output logic [DW-1:0] y
);
    genvar gi;
    generate
        for (gi = 0; gi < DW; gi++) begin : g_bit
            assign y[gi] = op[{a[gi], b[gi]}];
        end
    endgenerate
endmodule

module bool_arbiter #(
    parameter int NREQ = 2,
    parameter int DW   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid_i,
    output logic [NREQ-1:0]      req_ready_o,
    input  logic [NREQ*DW-1:0]   req_a_i,
    input  logic [NREQ*DW-1:0]   req_b_i,
    input  logic [NREQ*4-1:0]    req_op_i,
    output logic [NREQ-1:0]      rsp_valid_o,
    input  logic [NREQ-1:0]      rsp_ready_i,
    output logic [DW-1:0]        rsp_data_o,
    output logic                 busy_o
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {EMPTY, FULL} state_t;

    state_t           state_reg, state_next;
    logic [IDW-1:0]   owner_reg, owner_next;
    logic [IDW-1:0]   ptr_reg, ptr_next;
    logic [DW-1:0]    data_reg, data_next;

    logic [IDW-1:0]   grant;
    logic             found;
    logic             can_issue;
    logic             issue;
    int               idx;

    logic [DW-1:0]    a_arr  [NREQ];
    logic [DW-1:0]    b_arr  [NREQ];
    logic [3:0]       op_arr [NREQ];
    logic [DW-1:0]    unit_y;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign a_arr[gi]       = req_a_i[gi*DW +: DW];
            assign b_arr[gi]       = req_b_i[gi*DW +: DW];
            assign op_arr[gi]      = req_op_i[gi*4 +: 4];
            // Ready never depends on operand data, only on valid/pointer/slot state.
            assign req_ready_o[gi] = issue && (grant == IDW'(gi)) && !rst;
            assign rsp_valid_o[gi] = (state_reg == FULL) && (owner_reg == IDW'(gi));
        end
    endgenerate

    // First valid requester at or above the pointer, wrapping around.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_reg) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req_valid_i[idx]) begin
                found = 1'b1;
                grant = IDW'(idx);
            end
        end
    end

    assign can_issue = (state_reg == EMPTY) || rsp_ready_i[owner_reg];
    assign issue     = found && can_issue;

    bool_unit #(.DW(DW)) u_bool (
        .a  (a_arr[grant]),
        .b  (b_arr[grant]),
        .op (op_arr[grant]),
        .y  (unit_y)
    );

    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        ptr_next   = ptr_reg;
        data_next  = data_reg;
        if (issue) begin
            // A drain in the same cycle is absorbed by overwriting the slot.
            state_next = FULL;
            owner_next = grant;
            data_next  = unit_y;
            ptr_next   = (grant == IDW'(NREQ - 1)) ? '0 : grant + IDW'(1);
        end else if (state_reg == FULL && rsp_ready_i[owner_reg]) begin
            state_next = EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= EMPTY;
            owner_reg <= '0;
            ptr_reg   <= '0;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            ptr_reg   <= ptr_next;
            data_reg  <= data_next;
        end
    end

    assign rsp_data_o = data_reg;
    assign busy_o     = (state_reg == FULL);
endmodule
